hazard_scoreboard: RTL and testbench

- Parametrised successor to the processor's fixed load-use HDU and forwarding unit.
- Tracks every in-flight register writer in a DEPTH-slot shadow of the post-decode pipeline (slot 0 = EX … slot DEPTH-1 = WB).
- From that record it generates the decode stall, registered per-source forward selects aligned to EX, and flush bubbles.
- Supports NUM_SRC sources and a configurable load latency; the current design hard-wires both.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_scoreboard_match.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_hazard_scoreboard.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared scoreboard types and helpers for the hazard scoreboard slice.
// Pure definitions: no logic, no latency, no flow control.
package hazard_pkg;

    localparam int MAX_AW = 8;
    localparam int LAT_W  = 4;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [MAX_AW-1:0] dst;
        logic [LAT_W-1:0]  lat;
    } sb_entry_t;

    localparam int FWD_RF = 0;

    // Slot k at issue time has advanced to slot k+1 once the consumer reaches EX.
    function automatic int sel_for_slot(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// One source operand against every tracked slot: youngest-writer search, hazard and select.
// Purely combinational; no flow control.
module hazard_scoreboard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 3,
    parameter int SELW   = 2
) (
    input  sb_entry_t [DEPTH-1:0] slots,
    input  logic [REG_AW-1:0]     src_num,
    input  logic                  src_use,
    output logic                  hit,
    output logic                  hazard,
    output logic [SELW-1:0]       sel
);

    logic [MAX_AW-1:0] src_ext;
    logic              found;
    int                k_hit;
    int                lat_hit;

    assign src_ext = MAX_AW'(src_num);

    always_comb begin
        found   = 1'b0;
        k_hit   = 0;
        lat_hit = 0;
        // Walk oldest to youngest so the lowest matching slot is the one kept.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slots[k].valid && slots[k].wr && (slots[k].dst == src_ext)) begin
                found   = 1'b1;
                k_hit   = k;
                lat_hit = int'(slots[k].lat);
            end
        end
        hit    = src_use & found;
        hazard = hit & (k_hit < lat_hit);
        sel    = (hit && !hazard) ? SELW'(sel_for_slot(k_hit)) : SELW'(FWD_RF);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode hazard scoreboard: combinational stall, EX-aligned registered forward selects, flush bubbles.
// fwd_sel valid one cycle after issue; stall only injects bubbles, tracked slots never freeze.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = 2,
    parameter int CNTW     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [NUM_SRC*REG_AW-1:0] issue_src_num,
    input  logic [NUM_SRC-1:0]        issue_src_use,
    input  logic [REG_AW-1:0]         issue_dst_num,
    input  logic                      issue_dst_wr,
    input  logic                      issue_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic [DEPTH-1:0]          pipe_valid,
    output logic [CNTW-1:0]           stall_count
);

    localparam int REGS_SEEN = NUM_REGS;

    sb_entry_t [DEPTH-1:0]     slot_q, slot_d;
    sb_entry_t                 new_entry;
    logic [NUM_SRC*SELW-1:0]   fwd_sel_q, fwd_sel_d, sel_all;
    logic [CNTW-1:0]           stall_count_q, stall_count_d;
    logic [NUM_SRC-1:0]        src_hit, src_hazard;
    logic                      take;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [SELW-1:0] sel_g;

        hazard_scoreboard_match #(
            .DEPTH  (DEPTH),
            .REG_AW (REG_AW),
            .SELW   (SELW)
        ) u_match (
            .slots   (slot_q),
            .src_num (issue_src_num[g*REG_AW +: REG_AW]),
            .src_use (issue_src_use[g]),
            .hit     (src_hit[g]),
            .hazard  (src_hazard[g]),
            .sel     (sel_g)
        );

        assign sel_all[g*SELW +: SELW] = src_hit[g] ? sel_g : SELW'(FWD_RF);
    end

    // Flush wins over stall: a killed instruction must not hold the front end.
    assign stall = issue_valid & ~flush & (|src_hazard) & (REGS_SEEN > 0);
    assign take  = issue_valid & ~stall & ~flush;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.wr    = issue_dst_wr;
        new_entry.dst   = MAX_AW'(issue_dst_num);
        new_entry.lat   = issue_is_load ? LAT_W'(LOAD_LAT) : '0;

        slot_d    = '0;
        slot_d[0] = take ? new_entry : '0;
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end

        fwd_sel_d = take ? sel_all : '0;

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNTW{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q        <= '0;
            fwd_sel_q     <= '0;
            stall_count_q <= '0;
        end else begin
            slot_q        <= slot_d;
            fwd_sel_q     <= fwd_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        pipe_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pipe_valid[k] = slot_q[k].valid;
        end
    end

    assign fwd_sel     = fwd_sel_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default instance driven from a vector table, plus hand sequences for
// mid-operation reset and a DEPTH=5 / LOAD_LAT=2 / saturating 2-bit counter instance.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default instance (DEPTH=3, LOAD_LAT=1)
    logic        issue_valid, issue_dst_wr, issue_is_load, flush;
    logic [5:0]  issue_src_num;
    logic [1:0]  issue_src_use;
    logic [2:0]  issue_dst_num;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [2:0]  pipe_valid;
    logic [15:0] stall_count;

    hazard_scoreboard u_dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_src_num (issue_src_num),
        .issue_src_use (issue_src_use),
        .issue_dst_num (issue_dst_num),
        .issue_dst_wr  (issue_dst_wr),
        .issue_is_load (issue_is_load),
        .flush         (flush),
        .stall         (stall),
        .fwd_sel       (fwd_sel),
        .pipe_valid    (pipe_valid),
        .stall_count   (stall_count)
    );

    // Parametric instance (DEPTH=5, LOAD_LAT=2, CNTW=2)
    logic        p_valid, p_wr, p_ld;
    logic [5:0]  p_src_num;
    logic [1:0]  p_src_use;
    logic [2:0]  p_dst;
    logic        p_stall;
    logic [5:0]  p_fwd_sel;
    logic [4:0]  p_pipe_valid;
    logic [1:0]  p_count;

    hazard_scoreboard #(
        .NUM_REGS (8), .REG_AW (3), .NUM_SRC (2), .DEPTH (5),
        .LOAD_LAT (2), .SELW (3), .CNTW (2)
    ) u_dut_p (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (p_valid),
        .issue_src_num (p_src_num),
        .issue_src_use (p_src_use),
        .issue_dst_num (p_dst),
        .issue_dst_wr  (p_wr),
        .issue_is_load (p_ld),
        .flush         (1'b0),
        .stall         (p_stall),
        .fwd_sel       (p_fwd_sel),
        .pipe_valid    (p_pipe_valid),
        .stall_count   (p_count)
    );

    typedef struct {
        logic        v;
        logic [2:0]  s0, s1;
        logic [1:0]  su;
        logic [2:0]  dst;
        logic        wr, ld, fl;
        logic        e_stall;
        logic [1:0]  e_sel0, e_sel1;
        logic [2:0]  e_pv;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                                input logic [1:0] su, input logic [2:0] dst, input logic wr,
                                input logic ld, input logic fl, input logic e_stall,
                                input logic [1:0] e_sel0, input logic [1:0] e_sel1,
                                input logic [2:0] e_pv, input logic [15:0] e_cnt);
        vec_t t;
        t.v = v; t.s0 = s0; t.s1 = s1; t.su = su; t.dst = dst; t.wr = wr; t.ld = ld; t.fl = fl;
        t.e_stall = e_stall; t.e_sel0 = e_sel0; t.e_sel1 = e_sel1; t.e_pv = e_pv; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [1:0] su, input logic [2:0] dst, input logic wr,
                         input logic ld, input logic fl);
        issue_valid = v; issue_src_num = {s1, s0}; issue_src_use = su;
        issue_dst_num = dst; issue_dst_wr = wr; issue_is_load = ld; flush = fl;
    endtask

    task automatic p_cyc(input string name, input logic v, input logic [2:0] src,
                         input logic [2:0] dst, input logic wr, input logic ld,
                         input logic e_stall, input logic [2:0] e_sel0, input logic [1:0] e_cnt);
        @(negedge clk);
        p_valid = v; p_src_num = {3'd0, src}; p_src_use = {1'b0, v}; p_dst = dst;
        p_wr = wr; p_ld = ld;
        #1 chk({name, ".stall"}, 32'(p_stall), 32'(e_stall));
        @(posedge clk);
        #1;
        chk({name, ".sel0"}, 32'(p_fwd_sel[2:0]), 32'(e_sel0));
        chk({name, ".cnt"}, 32'(p_count), 32'(e_cnt));
    endtask

    vec_t tab[16];

    initial begin
        // cols: v s0 s1 use dst wr ld fl | stall sel0 sel1 pv cnt
        tab[0]  = mk(1, 0, 0, 2'b00, 3, 1, 0, 0,  0, 0, 0, 3'b001, 0); // I1 writes r3
        tab[1]  = mk(1, 3, 0, 2'b01, 6, 1, 0, 0,  0, 1, 0, 3'b011, 0); // back-to-back ALU
        tab[2]  = mk(1, 0, 0, 2'b00, 2, 1, 1, 0,  0, 0, 0, 3'b111, 0); // load r2
        tab[3]  = mk(1, 0, 2, 2'b10, 7, 1, 0, 0,  1, 0, 0, 3'b110, 1); // load-use stall
        tab[4]  = mk(1, 0, 2, 2'b10, 7, 1, 0, 0,  0, 0, 2, 3'b101, 1); // issues with sel 2
        tab[5]  = mk(1, 0, 0, 2'b00, 5, 1, 0, 0,  0, 0, 0, 3'b011, 1); // older r5 writer
        tab[6]  = mk(1, 0, 0, 2'b00, 5, 1, 0, 0,  0, 0, 0, 3'b111, 1); // younger r5 writer
        tab[7]  = mk(1, 5, 4, 2'b11, 4, 1, 0, 0,  0, 1, 0, 3'b111, 1); // youngest wins
        tab[8]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 3'b110, 1); // bubble
        tab[9]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 3'b100, 1); // bubble
        tab[10] = mk(1, 4, 4, 2'b01, 0, 0, 0, 0,  0, 3, 0, 3'b001, 1); // r4 in slot 2, unused src1
        tab[11] = mk(1, 4, 0, 2'b01, 0, 0, 0, 0,  0, 0, 0, 3'b011, 1); // r4 writer retired
        tab[12] = mk(1, 0, 0, 2'b00, 1, 1, 1, 0,  0, 0, 0, 3'b111, 1); // load r1
        tab[13] = mk(1, 1, 0, 2'b01, 3, 1, 0, 1,  0, 0, 0, 3'b110, 1); // flush beats hazard
        tab[14] = mk(1, 0, 0, 2'b00, 0, 1, 0, 0,  0, 0, 0, 3'b101, 1); // write r0
        tab[15] = mk(1, 0, 1, 2'b11, 6, 1, 0, 0,  0, 1, 3, 3'b011, 1); // r0 plain, r1 from slot 2

        reset = 1'b1;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        p_valid = 0; p_src_num = '0; p_src_use = '0; p_dst = '0; p_wr = 0; p_ld = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.stall", 32'(stall), 0);
        chk("rst.fwd", 32'(fwd_sel), 0);
        chk("rst.pv", 32'(pipe_valid), 0);
        chk("rst.cnt", 32'(stall_count), 0);
        chk("rst.p_pv", 32'(p_pipe_valid), 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tab[i].v, tab[i].s0, tab[i].s1, tab[i].su, tab[i].dst, tab[i].wr, tab[i].ld, tab[i].fl);
            #1 chk($sformatf("v%0d.stall", i), 32'(stall), 32'(tab[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.sel0", i), 32'(fwd_sel[1:0]), 32'(tab[i].e_sel0));
            chk($sformatf("v%0d.sel1", i), 32'(fwd_sel[3:2]), 32'(tab[i].e_sel1));
            chk($sformatf("v%0d.pv", i), 32'(pipe_valid), 32'(tab[i].e_pv));
            chk($sformatf("v%0d.cnt", i), 32'(stall_count), 32'(tab[i].e_cnt));
        end

        // Fill every slot with a forward pending, then reset mid-operation.
        @(negedge clk);
        drive(1, 6, 0, 2'b01, 2, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("mid.pv_full", 32'(pipe_valid), 32'h7);
        chk("mid.fwd_pre", 32'(fwd_sel), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 2, 0, 2'b01, 3, 1, 1, 0);
        @(posedge clk);
        #1;
        chk("mid.pv", 32'(pipe_valid), 0);
        chk("mid.cnt", 32'(stall_count), 0);
        chk("mid.fwd", 32'(fwd_sel), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 2, 0, 2'b01, 3, 1, 0, 0);
        #1 chk("post.stall", 32'(stall), 0);
        @(posedge clk);
        #1;
        chk("post.fwd", 32'(fwd_sel), 0);
        chk("post.pv", 32'(pipe_valid), 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);

        // DEPTH=5, LOAD_LAT=2: two stall cycles per load-use; 2-bit counter saturates.
        p_cyc("p.ld2",  1, 0, 2, 1, 1,  0, 0, 0);
        p_cyc("p.use1", 1, 2, 7, 1, 0,  1, 0, 1);
        p_cyc("p.use2", 1, 2, 7, 1, 0,  1, 0, 2);
        p_cyc("p.use3", 1, 2, 7, 1, 0,  0, 3, 2);
        chk("p.pv", 32'(p_pipe_valid), 32'b01001);
        p_cyc("p.ld3",  1, 0, 3, 1, 1,  0, 0, 2);
        p_cyc("p.use4", 1, 3, 6, 1, 0,  1, 0, 3);
        p_cyc("p.sat",  1, 3, 6, 1, 0,  1, 0, 3);
        p_cyc("p.use5", 1, 3, 6, 1, 0,  0, 3, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
